// File: rtl/deser_frame_ctrl.sv
// Sequencer for a 64-bit serial-to-parallel deserializer lane.
// Optional DESER_CTRL_STATS_EN adds saturating frame_cnt/drop_cnt outputs.
module deser_frame_ctrl #(
    parameter int FRAME_W = 64,
    parameter int CNT_W   = 7
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic               stop,
    input  logic               bit_vld,
    output logic               bit_rdy,
    output logic               deser_en,
    output logic               deser_clr,
    input  logic [FRAME_W-1:0] deser_p_data,
    output logic [FRAME_W-1:0] frame_data,
    output logic               frame_vld,
    input  logic               frame_rdy,
    output logic               busy,
    output logic               overflow,
    output logic [CNT_W-1:0]   bit_cnt
`ifdef DESER_CTRL_STATS_EN
    ,
    output logic [15:0]        frame_cnt,
    output logic [15:0]        drop_cnt
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CLR   = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] WRAP  = 2'd3;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_W - 1);

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               ovf_q, ovf_d;
    logic               vld_q, vld_d;
    logic [FRAME_W-1:0] data_q, data_d;

`ifdef DESER_CTRL_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
`endif

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        ovf_d     = ovf_q;
        data_d    = data_q;
        vld_d     = vld_q;
`ifdef DESER_CTRL_STATS_EN
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
`endif
        // A consumed frame retires unless a capture below refills it.
        if (vld_q && frame_rdy) begin
            vld_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = CLR;
                end
            end
            CLR: begin
                bit_cnt_d = '0;
                ovf_d     = 1'b0;
`ifdef DESER_CTRL_STATS_EN
                frame_cnt_d = '0;
                drop_cnt_d  = '0;
`endif
                state_d = stop ? IDLE : SHIFT;
            end
            SHIFT: begin
                if (stop) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end else if (bit_vld) begin
                    if (bit_cnt_q == LAST) begin
                        bit_cnt_d = '0;
                        state_d   = WRAP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            WRAP: begin
                if (!vld_q || frame_rdy) begin
                    data_d = deser_p_data;
                    vld_d  = 1'b1;
`ifdef DESER_CTRL_STATS_EN
                    if (frame_cnt_q != 16'hFFFF) begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end
`endif
                end else begin
                    ovf_d = 1'b1;
`ifdef DESER_CTRL_STATS_EN
                    if (drop_cnt_q != 16'hFFFF) begin
                        drop_cnt_d = drop_cnt_q + 16'd1;
                    end
`endif
                end
                state_d = stop ? IDLE : SHIFT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            ovf_q     <= 1'b0;
            vld_q     <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            ovf_q     <= ovf_d;
            vld_q     <= vld_d;
            data_q    <= data_d;
        end
    end

`ifdef DESER_CTRL_STATS_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;
`endif

    // WRAP drives the enable with no sample: the deserializer's rollover cycle.
    assign bit_rdy    = (state_q == SHIFT);
    assign deser_en   = (bit_rdy && bit_vld && !stop) || (state_q == WRAP);
    assign deser_clr  = (state_q == CLR);
    assign busy       = (state_q != IDLE);
    assign frame_data = data_q;
    assign frame_vld  = vld_q;
    assign overflow   = ovf_q;
    assign bit_cnt    = bit_cnt_q;

endmodule
